// File: rtl/cpu_pkg.sv
// Shared CPU constants: address/data widths, fetch FSM encoding, reset PC.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
//
// Imported by the fetch stage and by anything that has to agree with its
// state encoding or bus widths.
package cpu_pkg;

  // Instruction memory geometry (matches instmem addIM / dataIM / outIM).
  localparam int CPU_AW = 12;
  localparam int CPU_DW = 16;

  // PC loaded on reset and every time execution is (re)started from IDLE.
  localparam logic [CPU_AW-1:0] CPU_RESET_PC = 12'h000;

  // Fetch FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

endpackage : cpu_pkg

// File: rtl/inst_fetch.sv
// Fetch stage owning instmem's port: streams a program image in LOAD, fetches sequentially in RUN.
// Latency: 2 cycles from a PC on addIM to instr_valid with that word; 1 instr/cycle steady state.
// Backpressure: stall holds the whole fetch pipeline; load_ready=1 for every LOAD cycle.
//
// Ports:
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   load_en                request LOAD mode (wins over run_en in IDLE)
//   load_valid/load_data   program word to write; accepted whenever load_ready=1
//   load_ready             high for every cycle spent in LOAD
//   run_en                 request RUN mode; dropping it returns to IDLE
//   stall                  decode back-pressure
//   br_taken/br_target     redirect fetch; overrides stall
//   we_IM/addIM/dataIM     instmem write enable, address, write data
//   outIM                  instmem read data (synchronous read, 1-cycle)
//   instr/instr_pc         registered instruction word and its address
//   instr_valid            instr/instr_pc are meaningful
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int              AW       = CPU_AW,
  parameter int              DW       = CPU_DW,
  parameter logic [AW-1:0]   RESET_PC = CPU_RESET_PC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  input  logic          run_en,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic          we_IM,
  output logic [AW-1:0] addIM,
  output logic [DW-1:0] dataIM,
  input  logic [DW-1:0] outIM,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid
);

  // FSM and pipeline state.
  //   pc_q       : next address to be issued to instmem
  //   f_pc_q     : address issued last cycle, whose word is on outIM now
  //   f_vld_q    : outIM currently carries a correct-path word
  //   load_ptr_q : next write address while loading
  logic [1:0]    state_q,       state_d;
  logic [AW-1:0] pc_q,          pc_d;
  logic [AW-1:0] f_pc_q,        f_pc_d;
  logic          f_vld_q,       f_vld_d;
  logic [AW-1:0] load_ptr_q,    load_ptr_d;
  logic [DW-1:0] instr_q,       instr_d;
  logic [AW-1:0] instr_pc_q,    instr_pc_d;
  logic          instr_valid_q, instr_valid_d;

  // ---------------------------------------------------------------------
  // Instmem port drive (combinational)
  // ---------------------------------------------------------------------
  always_comb begin
    we_IM      = 1'b0;
    load_ready = 1'b0;
    dataIM     = '0;
    addIM      = pc_q;
    case (state_q)
      ST_LOAD: begin
        load_ready = 1'b1;
        we_IM      = load_valid;
        addIM      = load_ptr_q;
        dataIM     = load_data;
      end
      ST_RUN: begin
        // A branch must present its target now so the target word is on
        // outIM next cycle. During a stall, re-reading f_pc keeps outIM
        // pinned to the word waiting to be captured once the stall lifts.
        if (br_taken) begin
          addIM = br_target;
        end else if (stall) begin
          addIM = f_pc_q;
        end else begin
          addIM = pc_q;
        end
      end
      default: begin
        addIM = pc_q;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    f_pc_d        = f_pc_q;
    f_vld_d       = f_vld_q;
    load_ptr_d    = load_ptr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (load_en) begin
          state_d    = ST_LOAD;
          load_ptr_d = '0;
        end else if (run_en) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
          f_vld_d = 1'b0;
        end
      end

      ST_LOAD: begin
        // we_IM follows load_valid even on the exit cycle, so the pointer
        // advances with every write that actually lands in instmem.
        // Natural AW-bit overflow gives the FFF -> 000 wrap.
        if (load_valid) begin
          load_ptr_d = load_ptr_q + AW'(1);
        end
        if (!load_en) begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (!run_en) begin
          state_d       = ST_IDLE;
          instr_valid_d = 1'b0;
          f_vld_d       = 1'b0;
        end else if (br_taken) begin
          // The word on outIM this cycle is wrong-path: drop it, leaving a
          // one-cycle bubble, and start over from the target.
          f_pc_d        = br_target;
          pc_d          = br_target + AW'(1);
          f_vld_d       = 1'b1;
          instr_valid_d = 1'b0;
        end else if (!stall) begin
          instr_d       = outIM;
          instr_pc_d    = f_pc_q;
          instr_valid_d = f_vld_q;
          f_pc_d        = pc_q;
          pc_d          = pc_q + AW'(1);
          f_vld_d       = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      f_pc_q        <= '0;
      f_vld_q       <= 1'b0;
      load_ptr_q    <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      f_pc_q        <= f_pc_d;
      f_vld_q       <= f_vld_d;
      load_ptr_q    <= load_ptr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

endmodule : inst_fetch

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch with a behavioural instmem and reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_inst_fetch;
  import cpu_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_en, load_valid, run_en, stall, br_taken;
  logic [DW-1:0] load_data;
  logic [AW-1:0] br_target;
  logic          load_ready, we_IM, instr_valid;
  logic [AW-1:0] addIM, instr_pc;
  logic [DW-1:0] dataIM, instr;
  logic [DW-1:0] outIM = '0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .run_en(run_en), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .we_IM(we_IM), .addIM(addIM), .dataIM(dataIM), .outIM(outIM),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  // Behavioural instmem: synchronous read, write at the edge with we_IM=1.
  logic [DW-1:0] imem [0:4095] = '{default: '0};
  always @(posedge clk) begin
    if (we_IM) imem[addIM] <= dataIM;
    outIM <= imem[addIM];
  end

  // Reference model: golden program image plus the fetch rules in terms of
  // "next address to issue" and "word in flight".
  logic [DW-1:0] gold [0:4095] = '{default: '0};
  logic [AW-1:0] m_next, m_fl, m_ptr;
  bit            m_fl_ok;
  bit            e_valid;
  logic [DW-1:0] e_instr;
  logic [AW-1:0] e_pc, e_addr;
  // Combinational outputs captured just before the edge.
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_dat;
  logic          obs_we, obs_rdy;

  int checks   = 0;
  int failures = 0;

  // ---------------- drivers (no checking here) ----------------
  task automatic enter_load();
    @(negedge clk);
    load_en = 1'b1; run_en = 1'b0; load_valid = 1'b0;
    @(posedge clk); #1;
    m_ptr = '0;
  endtask

  task automatic load_cycle(input bit vld, input logic [DW-1:0] d);
    @(negedge clk);
    load_valid = vld; load_data = d; #1;
    obs_we = we_IM; obs_addr = addIM; obs_dat = dataIM; obs_rdy = load_ready;
    e_addr = m_ptr;
    @(posedge clk);
    if (vld) begin
      gold[m_ptr] = d;
      m_ptr = m_ptr + 1'b1;
    end
    #1;
  endtask

  task automatic exit_load();
    @(negedge clk);
    load_en = 1'b0; load_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic enter_run();
    @(negedge clk);
    run_en = 1'b1; load_en = 1'b0; br_taken = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    m_next = CPU_RESET_PC; m_fl_ok = 1'b0; e_valid = 1'b0;
  endtask

  task automatic run_cycle(input bit br, input logic [AW-1:0] tgt, input bit st);
    @(negedge clk);
    br_taken = br; br_target = tgt; stall = st; #1;
    obs_addr = addIM; obs_we = we_IM;
    if (br) begin
      e_addr = tgt; m_fl = tgt; m_fl_ok = 1'b1; m_next = tgt + 1'b1; e_valid = 1'b0;
    end else if (st) begin
      e_addr = m_fl;
    end else begin
      e_addr = m_next;
      e_valid = m_fl_ok; e_instr = gold[m_fl]; e_pc = m_fl;
      m_fl = m_next; m_fl_ok = 1'b1; m_next = m_next + 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic exit_run();
    @(negedge clk);
    run_en = 1'b0; br_taken = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    e_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; load_en = 0; load_valid = 0; load_data = '0; run_en = 0;
    stall = 0; br_taken = 0; br_target = '0;
    #12;
    checks++;
    if ({instr, instr_pc, instr_valid, we_IM, load_ready, dataIM} !== '0) begin
      failures++;
      $display("FAIL reset_outputs instr=%h pc=%h vld=%b we=%b rdy=%b dat=%h (all must be 0)",
               instr, instr_pc, instr_valid, we_IM, load_ready, dataIM);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (load_ready !== 1'b0 || we_IM !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset rdy=%b we=%b expected 0/0", load_ready, we_IM);
    end
  endtask

  task automatic test_load_run();
    logic [DW-1:0] w [3];
    w[0] = 16'h0234; w[1] = 16'h0381; w[2] = 16'h1111;
    enter_load();
    for (int i = 0; i < 3; i++) begin
      load_cycle(1'b1, w[i]);
      checks++;
      if (obs_we !== 1'b1 || obs_addr !== AW'(i) || obs_dat !== w[i] || obs_rdy !== 1'b1 ||
          instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL load_word%0d we=%b addr=%h dat=%h rdy=%b vld=%b expected 1/%h/%h/1/0",
                 i, obs_we, obs_addr, obs_dat, obs_rdy, instr_valid, AW'(i), w[i]);
      end
      if (i == 1) begin
        load_cycle(1'b0, 16'hDEAD);
        checks++;
        if (obs_we !== 1'b0 || obs_addr !== 12'h002 || obs_rdy !== 1'b1) begin
          failures++;
          $display("FAIL load_gap we=%b addr=%h rdy=%b expected 0/002/1", obs_we, obs_addr, obs_rdy);
        end
      end
    end
    exit_load();
    enter_run();
    run_cycle(1'b0, '0, 1'b0);
    checks++;
    if (instr_valid !== 1'b0 || obs_addr !== 12'h000) begin
      failures++;
      $display("FAIL run_first_edge vld=%b addr=%h expected 0/000", instr_valid, obs_addr);
    end
    run_cycle(1'b0, '0, 1'b0);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'h0234 || instr_pc !== 12'h000) begin
      failures++;
      $display("FAIL run_instr0 vld=%b instr=%h pc=%h expected 1/0234/000", instr_valid, instr, instr_pc);
    end
    run_cycle(1'b0, '0, 1'b0);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'h0381 || instr_pc !== 12'h001) begin
      failures++;
      $display("FAIL run_instr1 vld=%b instr=%h pc=%h expected 1/0381/001", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b0, '0, 1'b1);
      checks++;
      if (instr_valid !== 1'b1 || instr !== 16'h0381 || instr_pc !== 12'h001 ||
          obs_addr !== 12'h002 || obs_we !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d vld=%b instr=%h pc=%h addr=%h we=%b expected 1/0381/001/002/0",
                 i, instr_valid, instr, instr_pc, obs_addr, obs_we);
      end
    end
    run_cycle(1'b0, '0, 1'b0);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'h1111 || instr_pc !== 12'h002) begin
      failures++;
      $display("FAIL stall_release vld=%b instr=%h pc=%h expected 1/1111/002", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_branch();
    run_cycle(1'b1, 12'h000, 1'b0);
    checks++;
    if (instr_valid !== 1'b0 || obs_addr !== 12'h000) begin
      failures++;
      $display("FAIL branch_bubble vld=%b addr=%h expected 0/000", instr_valid, obs_addr);
    end
    run_cycle(1'b0, '0, 1'b0);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'h0234 || instr_pc !== 12'h000) begin
      failures++;
      $display("FAIL branch_target vld=%b instr=%h pc=%h expected 1/0234/000", instr_valid, instr, instr_pc);
    end
    run_cycle(1'b0, '0, 1'b0);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'h0381 || instr_pc !== 12'h001) begin
      failures++;
      $display("FAIL branch_next vld=%b instr=%h pc=%h expected 1/0381/001", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_branch_stall();
    run_cycle(1'b1, 12'h001, 1'b1);
    checks++;
    if (instr_valid !== 1'b0 || obs_addr !== 12'h001) begin
      failures++;
      $display("FAIL brstall_bubble vld=%b addr=%h expected 0/001", instr_valid, obs_addr);
    end
    run_cycle(1'b0, '0, 1'b0);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'h0381 || instr_pc !== 12'h001) begin
      failures++;
      $display("FAIL brstall_target vld=%b instr=%h pc=%h expected 1/0381/001", instr_valid, instr, instr_pc);
    end
    exit_run();
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL run_exit vld=%b expected 0", instr_valid);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] d;
    int bad = 0;
    enter_load();
    for (int i = 0; i < 4097; i++) begin
      d = (i == 4095) ? 16'hAAAA : (i == 4096) ? 16'h0234 : DW'($urandom);
      load_cycle(1'b1, d);
      checks++;
      if (obs_we !== 1'b1 || obs_addr !== AW'(i) || obs_dat !== d) begin
        failures++;
        bad++;
        if (bad < 5)
          $display("FAIL load_wrap%0d we=%b addr=%h dat=%h expected 1/%h/%h",
                   i, obs_we, obs_addr, obs_dat, AW'(i), d);
      end
    end
    exit_load();
    checks++;
    if (imem[0] !== 16'h0234 || imem[4095] !== 16'hAAAA) begin
      failures++;
      $display("FAIL load_ptr_wrap mem0=%h memFFF=%h expected 0234/AAAA", imem[0], imem[4095]);
    end
    enter_run();
    run_cycle(1'b1, 12'hFFF, 1'b0);
    run_cycle(1'b0, '0, 1'b0);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'hAAAA || instr_pc !== 12'hFFF) begin
      failures++;
      $display("FAIL pc_wrap_fff vld=%b instr=%h pc=%h expected 1/AAAA/FFF", instr_valid, instr, instr_pc);
    end
    run_cycle(1'b0, '0, 1'b0);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'h0234 || instr_pc !== 12'h000) begin
      failures++;
      $display("FAIL pc_wrap_000 vld=%b instr=%h pc=%h expected 1/0234/000", instr_valid, instr, instr_pc);
    end
  endtask

  // Continues in RUN from test_wrap with a fully random program image.
  task automatic test_random();
    bit br, st;
    logic [AW-1:0] tgt;
    int bad = 0;
    for (int n = 0; n < 400; n++) begin
      br  = ($urandom_range(0, 7) == 0);
      st  = ($urandom_range(0, 3) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 12'hFFE + AW'($urandom_range(0, 1)) : AW'($urandom);
      run_cycle(br, tgt, st);
      checks++;
      if (obs_addr !== e_addr || obs_we !== 1'b0 || instr_valid !== e_valid ||
          (e_valid && (instr !== e_instr || instr_pc !== e_pc))) begin
        failures++;
        bad++;
        if (bad < 5)
          $display("FAIL random%0d addr=%h vld=%b instr=%h pc=%h expected %h/%b/%h/%h",
                   n, obs_addr, instr_valid, instr, instr_pc, e_addr, e_valid, e_instr, e_pc);
      end
    end
    exit_run();
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL random_exit vld=%b expected 0", instr_valid);
    end
  endtask

  task automatic test_reset_mid();
    // Mid-load
    enter_load();
    load_cycle(1'b1, 16'h5555);
    @(negedge clk);
    load_valid = 1'b1; load_data = 16'h7777;
    #2 rst_n = 1'b0; #1;
    checks++;
    if (we_IM !== 1'b0 || load_ready !== 1'b0 || dataIM !== '0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_load we=%b rdy=%b dat=%h vld=%b expected 0/0/0000/0",
               we_IM, load_ready, dataIM, instr_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (we_IM !== 1'b0 || imem[1] !== gold[1]) begin
      failures++;
      $display("FAIL reset_no_write we=%b mem1=%h expected 0/%h", we_IM, imem[1], gold[1]);
    end
    @(negedge clk);
    load_en = 1'b0; load_valid = 1'b0; rst_n = 1'b1;
    // Mid-run
    enter_run();
    for (int i = 0; i < 3; i++) run_cycle(1'b0, '0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0; #1;
    checks++;
    if ({instr, instr_pc, instr_valid, we_IM, load_ready, dataIM} !== '0) begin
      failures++;
      $display("FAIL reset_mid_run instr=%h pc=%h vld=%b we=%b rdy=%b dat=%h (all must be 0)",
               instr, instr_pc, instr_valid, we_IM, load_ready, dataIM);
    end
    @(negedge clk);
    run_en = 1'b0; rst_n = 1'b1;
    // Back in IDLE: a fresh run restarts at RESET_PC with the 2-edge latency.
    enter_run();
    run_cycle(1'b0, '0, 1'b0);
    run_cycle(1'b0, '0, 1'b0);
    checks++;
    if (instr_valid !== 1'b1 || instr !== gold[0] || instr_pc !== 12'h000) begin
      failures++;
      $display("FAIL restart_after_reset vld=%b instr=%h pc=%h expected 1/%h/000",
               instr_valid, instr, instr_pc, gold[0]);
    end
    exit_run();
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_stall();
    test_branch();
    test_branch_stall();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule : tb_inst_fetch
